// File: rtl/mem_wb_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_wb_stage_pkg : opcodes, CC bit indices and FSM encoding for mem_wb_stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_wb_stage_pkg;

  localparam logic [1:0] OP_BR  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_LDW = 2'b10;
  localparam logic [1:0] OP_STW = 2'b11;

  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  localparam logic [2:0] CC_RESET = 3'b010;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == OP_LDW) || (op == OP_STW);
  endfunction

  function automatic logic writes_back(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_LDW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_cc_gen.sv
// ----------------------------------------------------------------------------
// cc_gen : combinational {N,Z,P} condition-code generator for a 16-bit value
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cc_gen
  import mem_wb_stage_pkg::*;
(
  input  logic [15:0] i_value,
  output logic [2:0]  o_cc
);

  always_comb begin
    o_cc       = 3'b000;
    o_cc[CC_N] = i_value[15];
    o_cc[CC_Z] = (i_value == 16'h0000);
    o_cc[CC_P] = !i_value[15] && (i_value != 16'h0000);
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ----------------------------------------------------------------------------
// mem_wb_stage : memory-access and writeback stage with req/ack data memory
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EX_VALID,
  input  logic [1:0]  EX_OP,
  input  logic [2:0]  EX_DR,
  input  logic [15:0] EX_RESULT,
  input  logic [15:0] EX_STORE_DATA,
  output logic        MEM_STALL,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [15:0] DMEM_ADDR,
  output logic [15:0] DMEM_WDATA,
  input  logic [15:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic [1:0]  OP_MEM,
  output logic [2:0]  DR_MEM,
  output logic [15:0] MEM_RESULT,
  output logic        WB_ENABLE,
  output logic [2:0]  DR_WB,
  output logic [15:0] WB_RESULT,
  output logic [2:0]  CC,
  output logic        MEM_ERR
);

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  logic        r_valid;
  logic [1:0]  r_op;
  logic [2:0]  r_dr;
  logic [15:0] r_result;
  logic [15:0] r_sdata;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [7:0]  w_cnt_inc;

  logic        r_wb_en;
  logic [2:0]  r_dr_wb;
  logic [15:0] r_wb_result;
  logic [2:0]  r_cc;
  logic        r_mem_err;

  logic        w_is_mem;
  logic        w_abort;
  logic        w_req;
  logic        w_stall;
  logic        w_wb_en;
  logic [15:0] w_mem_result;
  logic [2:0]  w_cc_new;

  assign w_is_mem  = r_valid && is_mem_op(r_op);
  assign w_cnt_inc = r_cnt + 8'd1;
  // The last waiting cycle is the abort cycle itself, so the stall spans exactly TIMEOUT cycles.
  assign w_abort   = (r_state == S_WAIT) && !DMEM_ACK && (w_cnt_inc == c_timeout);
  assign w_req     = w_is_mem && !w_abort;
  assign w_stall   = w_req && !DMEM_ACK;

  assign w_mem_result = (r_valid && (r_op == OP_LDW)) ? DMEM_RDATA : r_result;
  assign w_wb_en      = r_valid && writes_back(r_op) && !w_abort && !w_stall;

  cc_gen u_cc_gen (
    .i_value (w_mem_result),
    .o_cc    (w_cc_new)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_valid  <= 1'b0;
      r_op     <= OP_BR;
      r_dr     <= 3'd0;
      r_result <= 16'h0000;
      r_sdata  <= 16'h0000;
    end else if (!w_stall) begin
      r_valid  <= EX_VALID;
      r_op     <= EX_OP;
      r_dr     <= EX_DR;
      r_result <= EX_RESULT;
      r_sdata  <= EX_STORE_DATA;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_is_mem && !DMEM_ACK) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_WAIT: begin
        if (DMEM_ACK || w_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // WB_ENABLE reloads every edge so stall cycles retire as bubbles.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wb_en     <= 1'b0;
      r_dr_wb     <= 3'd0;
      r_wb_result <= 16'h0000;
      r_cc        <= CC_RESET;
      r_mem_err   <= 1'b0;
    end else begin
      r_wb_en <= w_wb_en;
      if (!w_stall) begin
        r_dr_wb     <= r_dr;
        r_wb_result <= w_mem_result;
      end
      if (w_wb_en) begin
        r_cc <= w_cc_new;
      end
      if (w_abort) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign MEM_STALL  = w_stall;
  assign DMEM_REQ   = w_req;
  assign DMEM_WE    = (r_op == OP_STW);
  assign DMEM_ADDR  = {r_result[15:1], 1'b0};
  assign DMEM_WDATA = r_sdata;
  assign OP_MEM     = r_valid ? r_op : OP_BR;
  assign DR_MEM     = r_dr;
  assign MEM_RESULT = w_mem_result;
  assign WB_ENABLE  = r_wb_en;
  assign DR_WB      = r_dr_wb;
  assign WB_RESULT  = r_wb_result;
  assign CC         = r_cc;
  assign MEM_ERR    = r_mem_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_wb_stage : directed + random bench for mem_wb_stage with a
// per-instruction reference model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_wb_stage;

  localparam int TMO = 3;
  localparam logic [1:0] BR  = 2'b00;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] LDW = 2'b10;
  localparam logic [1:0] STW = 2'b11;

  logic        CLK;
  logic        RESET_N;
  logic        EX_VALID;
  logic [1:0]  EX_OP;
  logic [2:0]  EX_DR;
  logic [15:0] EX_RESULT;
  logic [15:0] EX_STORE_DATA;
  logic        MEM_STALL;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [15:0] DMEM_ADDR;
  logic [15:0] DMEM_WDATA;
  logic [15:0] DMEM_RDATA;
  logic        DMEM_ACK;
  logic [1:0]  OP_MEM;
  logic [2:0]  DR_MEM;
  logic [15:0] MEM_RESULT;
  logic        WB_ENABLE;
  logic [2:0]  DR_WB;
  logic [15:0] WB_RESULT;
  logic [2:0]  CC;
  logic        MEM_ERR;

  mem_wb_stage #(.TIMEOUT(TMO)) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .EX_VALID      (EX_VALID),
    .EX_OP         (EX_OP),
    .EX_DR         (EX_DR),
    .EX_RESULT     (EX_RESULT),
    .EX_STORE_DATA (EX_STORE_DATA),
    .MEM_STALL     (MEM_STALL),
    .DMEM_REQ      (DMEM_REQ),
    .DMEM_WE       (DMEM_WE),
    .DMEM_ADDR     (DMEM_ADDR),
    .DMEM_WDATA    (DMEM_WDATA),
    .DMEM_RDATA    (DMEM_RDATA),
    .DMEM_ACK      (DMEM_ACK),
    .OP_MEM        (OP_MEM),
    .DR_MEM        (DR_MEM),
    .MEM_RESULT    (MEM_RESULT),
    .WB_ENABLE     (WB_ENABLE),
    .DR_WB         (DR_WB),
    .WB_RESULT     (WB_RESULT),
    .CC            (CC),
    .MEM_ERR       (MEM_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: the instruction sitting in the MEM latch, how many
  // cycles memory makes it wait, and the expected registered WB outputs.
  logic        cur_v;
  logic [1:0]  cur_op;
  logic [2:0]  cur_dr;
  logic [15:0] cur_res, cur_sd, cur_rd;
  int          cur_waits, cur_c;
  logic        exp_wb_en;
  logic [2:0]  exp_dr_wb;
  logic [15:0] exp_wb_res;
  logic [2:0]  exp_cc;
  logic        exp_err;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    else if (v == 16'h0000) return 3'b010;
    else return 3'b001;
  endfunction

  task automatic model_reset();
    cur_v = 1'b0; cur_op = BR; cur_dr = 3'd0;
    cur_res = 16'h0; cur_sd = 16'h0; cur_rd = 16'h0;
    cur_waits = 0; cur_c = 0;
    exp_wb_en = 1'b0; exp_dr_wb = 3'd0; exp_wb_res = 16'h0;
    exp_cc = 3'b010; exp_err = 1'b0;
  endtask

  // One clock cycle: present an EX instruction (with the wait states memory
  // will insert for it), play the memory side, check, then advance the model.
  task automatic cycle(input logic ev, input logic [1:0] eop, input logic [2:0] edr,
                       input logic [15:0] eres, input logic [15:0] esd,
                       input int ewaits, input logic [15:0] erd, output bit consumed);
    bit mem, ack_now, abort_now, stall_now;
    logic [15:0] rd_now, fwd;
    mem       = cur_v && (cur_op == LDW || cur_op == STW);
    ack_now   = mem && (cur_waits < TMO) && (cur_c == cur_waits);
    abort_now = mem && (cur_waits >= TMO) && (cur_c == TMO);
    stall_now = mem && !ack_now && !abort_now;
    rd_now    = ack_now ? cur_rd : 16'($urandom);
    EX_VALID = ev; EX_OP = eop; EX_DR = edr; EX_RESULT = eres; EX_STORE_DATA = esd;
    DMEM_ACK = ack_now; DMEM_RDATA = rd_now;
    #1;
    fwd = (cur_v && cur_op == LDW) ? rd_now : cur_res;
    chk("dmem_req", 16'(DMEM_REQ), 16'(mem && !abort_now));
    chk("mem_stall", 16'(MEM_STALL), 16'(stall_now));
    if (mem && !abort_now) begin
      chk("dmem_addr", DMEM_ADDR, cur_res & 16'hFFFE);
      chk("dmem_we", 16'(DMEM_WE), 16'(cur_op == STW));
      if (cur_op == STW) chk("dmem_wdata", DMEM_WDATA, cur_sd);
    end
    chk("op_mem", 16'(OP_MEM), 16'(cur_v ? cur_op : 2'b00));
    chk("dr_mem", 16'(DR_MEM), 16'(cur_dr));
    chk("mem_result", MEM_RESULT, fwd);
    chk("wb_enable", 16'(WB_ENABLE), 16'(exp_wb_en));
    chk("dr_wb", 16'(DR_WB), 16'(exp_dr_wb));
    chk("wb_result", WB_RESULT, exp_wb_res);
    chk("cc", 16'(CC), 16'(exp_cc));
    chk("mem_err", 16'(MEM_ERR), 16'(exp_err));
    if (stall_now) begin
      exp_wb_en = 1'b0;
      cur_c = cur_c + 1;
      consumed = 1'b0;
    end else begin
      exp_wb_en  = cur_v && (cur_op == ADD || cur_op == LDW) && !abort_now;
      exp_dr_wb  = cur_dr;
      exp_wb_res = fwd;
      if (exp_wb_en) exp_cc = cc_of(fwd);
      if (abort_now) exp_err = 1'b1;
      cur_v = ev; cur_op = eop; cur_dr = edr; cur_res = eres; cur_sd = esd;
      cur_waits = ewaits; cur_rd = erd; cur_c = 0;
      consumed = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    bit t;
    repeat (n) cycle(1'b0, BR, 3'd0, 16'h0, 16'h0, 0, 16'h0, t);
  endtask

  initial begin
    bit          took;
    logic        pv;
    logic [1:0]  pop;
    logic [2:0]  pdr;
    logic [15:0] pres, psd, prd;
    int          pw;

    RESET_N = 1'b1; EX_VALID = 1'b0; EX_OP = BR; EX_DR = 3'd0;
    EX_RESULT = 16'h0; EX_STORE_DATA = 16'h0; DMEM_RDATA = 16'h0; DMEM_ACK = 1'b0;
    #2 RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req", 16'(DMEM_REQ), 16'h0);
    chk("rst_stall", 16'(MEM_STALL), 16'h0);
    chk("rst_wb_en", 16'(WB_ENABLE), 16'h0);
    chk("rst_op_mem", 16'(OP_MEM), 16'h0);
    chk("rst_dr_mem", 16'(DR_MEM), 16'h0);
    chk("rst_dr_wb", 16'(DR_WB), 16'h0);
    chk("rst_mem_result", MEM_RESULT, 16'h0);
    chk("rst_wb_result", WB_RESULT, 16'h0);
    chk("rst_cc", 16'(CC), 16'h0002);
    chk("rst_mem_err", 16'(MEM_ERR), 16'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    model_reset();

    // ADD retire
    cycle(1'b1, ADD, 3'd3, 16'hFFFE, 16'h0, 0, 16'h0, took);
    idle(1);
    chk("add_wb_en", 16'(WB_ENABLE), 16'h1);
    chk("add_dr_wb", 16'(DR_WB), 16'h3);
    chk("add_wb_result", WB_RESULT, 16'hFFFE);
    chk("add_cc", 16'(CC), 16'h0004);

    // STW, zero wait states: CC must stay 100
    cycle(1'b1, STW, 3'd0, 16'h0010, 16'h1234, 0, 16'h0, took);
    idle(1);
    chk("stw_wb_en", 16'(WB_ENABLE), 16'h0);
    chk("stw_cc", 16'(CC), 16'h0004);

    // LDW with 2 wait states returning zero
    cycle(1'b1, LDW, 3'd5, 16'h0041, 16'h0, 2, 16'h0000, took);
    idle(3);
    chk("ldw_wb_en", 16'(WB_ENABLE), 16'h1);
    chk("ldw_dr_wb", 16'(DR_WB), 16'h5);
    chk("ldw_wb_result", WB_RESULT, 16'h0000);
    chk("ldw_cc", 16'(CC), 16'h0002);

    // Timeout: never acked
    cycle(1'b1, LDW, 3'd2, 16'h0100, 16'h0, 99, 16'h0, took);
    idle(4);
    chk("tmo_err", 16'(MEM_ERR), 16'h1);
    chk("tmo_wb_en", 16'(WB_ENABLE), 16'h0);
    chk("tmo_cc", 16'(CC), 16'h0002);
    cycle(1'b1, ADD, 3'd1, 16'h0005, 16'h0, 0, 16'h0, took);
    idle(1);
    chk("post_tmo_wb_en", 16'(WB_ENABLE), 16'h1);
    chk("post_tmo_wb_result", WB_RESULT, 16'h0005);
    chk("post_tmo_cc", 16'(CC), 16'h0001);
    chk("post_tmo_err", 16'(MEM_ERR), 16'h1);

    // Random traffic; a pending instruction is held until the stage takes it
    pv = 1'b1; pop = 2'($urandom); pdr = 3'($urandom); pres = 16'($urandom);
    psd = 16'($urandom); pw = $urandom_range(0, 4); prd = 16'($urandom);
    for (int i = 0; i < 300; i++) begin
      cycle(pv, pop, pdr, pres, psd, pw, prd, took);
      if (took) begin
        pv = ($urandom_range(0, 3) != 0);
        pop = 2'($urandom); pdr = 3'($urandom);
        pres = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        psd = 16'($urandom); pw = $urandom_range(0, 4);
        prd = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      end
    end
    idle(6);

    // Reset in the middle of a waiting LDW
    cycle(1'b1, LDW, 3'd4, 16'h0200, 16'h0, 99, 16'h0, took);
    idle(2);
    RESET_N = 1'b0;
    #1;
    chk("rmid_req", 16'(DMEM_REQ), 16'h0);
    chk("rmid_stall", 16'(MEM_STALL), 16'h0);
    chk("rmid_wb_en", 16'(WB_ENABLE), 16'h0);
    chk("rmid_op_mem", 16'(OP_MEM), 16'h0);
    chk("rmid_mem_result", MEM_RESULT, 16'h0);
    chk("rmid_wb_result", WB_RESULT, 16'h0);
    chk("rmid_dr_wb", 16'(DR_WB), 16'h0);
    chk("rmid_cc", 16'(CC), 16'h0002);
    chk("rmid_err", 16'(MEM_ERR), 16'h0);
    @(negedge CLK);
    EX_VALID = 1'b0; EX_OP = BR; EX_DR = 3'd0; EX_RESULT = 16'h0; EX_STORE_DATA = 16'h0;
    DMEM_ACK = 1'b1; DMEM_RDATA = 16'hBEEF;
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("late_ack_wb_en", 16'(WB_ENABLE), 16'h0);
    chk("late_ack_req", 16'(DMEM_REQ), 16'h0);
    chk("late_ack_wb_result", WB_RESULT, 16'h0);
    chk("late_ack_cc", 16'(CC), 16'h0002);
    DMEM_ACK = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and writeback stage of the 16-bit 5-stage pipeline. It accepts one instruction per cycle from the execute/address-generation stage and performs the data-memory read or write over a req/ack handshake. It presents the forwarding values (`OP_MEM`, `DR_MEM`, `MEM_RESULT`) consumed by decode, and drives the register-file write port (`WB_ENABLE`, `DR_WB`, `WB_RESULT`) and the N/Z/P condition codes (`CC`) that decode reads.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum wait cycles for `DMEM_ACK` before a memory access is aborted. Range 1..255.

Ports:
- `CLK` in 1: clock, rising edge.
- `RESET_N` in 1: reset, asynchronous assert, active-low.
- `EX_VALID` in 1: execute stage presents an instruction.
- `EX_OP` in 2: operation code. 00 BR, 01 ADD, 10 LDW, 11 STW.
- `EX_DR` in 3: destination register. For STW this field is unused.
- `EX_RESULT` in 16: ADD sum, or LDW/STW byte address.
- `EX_STORE_DATA` in 16: STW data.
- `MEM_STALL` out 1: freeze upstream stages.
- `DMEM_REQ` out 1: memory request.
- `DMEM_WE` out 1: 1 = write (STW).
- `DMEM_ADDR` out 16: word-aligned byte address.
- `DMEM_WDATA` out 16: store data.
- `DMEM_RDATA` in 16: load data, valid when `DMEM_ACK` is high.
- `DMEM_ACK` in 1: access complete.
- `OP_MEM` out 2: opcode held in the MEM latch. 00 when the latch is empty.
- `DR_MEM` out 3: destination register held in the MEM latch.
- `MEM_RESULT` out 16: forwarding value from the MEM stage.
- `WB_ENABLE` out 1: register-file write enable.
- `DR_WB` out 3: write register number.
- `WB_RESULT` out 16: write data.
- `CC` out 3: condition codes. {N,Z,P}.
- `MEM_ERR` out 1: sticky flag, set when an access times out.

## Operation
- **MEM latch** (valid, op, dr, result, store data):
  - Loads when `!MEM_STALL`. Valid is set to `EX_VALID`.
  - Holds its contents while `MEM_STALL` is high.
- **FSM states:** `S_IDLE`, `S_WAIT`.
  - `S_IDLE` → `S_WAIT` when the latch is valid, op is LDW or STW, and `DMEM_ACK` is low.
  - `S_WAIT` → `S_IDLE` on `DMEM_ACK` or on timeout.
- **Memory request:**
  - `DMEM_REQ` = latch valid & op ∈ {LDW, STW} & not aborted.
  - `DMEM_ADDR` = {result[15:1], 1'b0}.
  - `DMEM_WE` = (op == STW).
  - `DMEM_WDATA` = latched store data.
- **Stall:** `MEM_STALL` = `DMEM_REQ` & `!DMEM_ACK`. This is a combinational path from `DMEM_ACK`.
  - An ack in the first request cycle completes the access with zero wait states.
- **Wait counter (8-bit):**
  - Cleared on entering `S_WAIT`. Increments each cycle in `S_WAIT` without ack.
  - When the count reaches `TIMEOUT`, the access aborts:
    - `MEM_ERR` is set.
    - The instruction retires as a bubble: no writeback, CC unchanged.
    - `MEM_STALL` drops in that cycle.
- **Forwarding outputs:**
  - `MEM_RESULT` = `DMEM_RDATA` for LDW, otherwise the latched result.
  - `OP_MEM` and `DR_MEM` come from the latch. `OP_MEM` = 00 when the latch is invalid.
- **WB register:** loads at every edge where `!MEM_STALL`.
  - `WB_ENABLE` = latch valid & op ∈ {ADD, LDW} & not aborted.
  - `DR_WB` = latched dr.
  - `WB_RESULT` = `MEM_RESULT`.
- **CC:** updated at the same edge from the value entering `WB_RESULT`, only when that writeback is enabled.
  - N = bit 15.
  - Z = value == 0.
  - P = neither N nor Z.
- BR and STW never write back and never change CC.

## Timing
- **Reset values:**
  - All valids cleared. FSM = `S_IDLE`. Counter = 0.
  - `DMEM_REQ` = 0, `MEM_STALL` = 0, `WB_ENABLE` = 0.
  - `OP_MEM` = 00, `DR_MEM` = 0, `DR_WB` = 0, `MEM_RESULT` = 0, `WB_RESULT` = 0.
  - `CC` = 3'b010, `MEM_ERR` = 0.
- **Reset mid-access:** `DMEM_REQ` drops asynchronously. The outstanding access is discarded and no writeback occurs.
- **Latency:** the WB outputs appear 1 cycle after the instruction enters the latch, plus any wait states.
- **Stall cycles:**
  - The WB register still loads; its contents are `WB_ENABLE` = 0, bubble.
  - The latch holds. Upstream must hold its outputs.
- **Simultaneous events:**
  - Ack on the same edge as a new EX instruction: the latch loads the new instruction and WB retires the old one.
  - Back-to-back LDWs each perform their own handshake.
- `MEM_ERR` clears only on reset.

## Structure
- **Shared package:**
  - Opcode constants `OP_BR`, `OP_ADD`, `OP_LDW`, `OP_STW`.
  - CC bit indices.
  - FSM state encoding.
- **Sub-module `cc_gen`:** combinational; 16-bit value in, {N,Z,P} out. Reusable by the branch logic.
- All remaining logic lives in `mem_wb_stage`.

## Test plan
- **ADD retire:** `EX_OP`=01, `EX_DR`=3, `EX_RESULT`=16'hFFFE → next cycle `WB_ENABLE`=1, `DR_WB`=3, `WB_RESULT`=FFFE, `CC`=100. `DMEM_REQ` never asserts.
- **LDW, 2 wait states:** `EX_RESULT`=16'h0041, `DMEM_RDATA`=0 with ack on the 3rd request cycle → `DMEM_ADDR`=0040, `MEM_STALL` high for 2 cycles, then `WB_RESULT`=0, `CC`=010. `MEM_RESULT` equals `DMEM_RDATA` in the ack cycle.
- **STW, zero wait:** ack in the same cycle as `EX_STORE_DATA`=16'h1234, addr 0x0010 → `DMEM_WE`=1, `DMEM_WDATA`=1234, no stall, `WB_ENABLE`=0, CC unchanged.
- **Timeout:** `TIMEOUT`=3, no ack → `MEM_STALL` high for 3 cycles then drops. `MEM_ERR`=1, no writeback. The next ADD proceeds normally.
- **Reset mid-LDW:** `RESET_N` low during `S_WAIT` → `DMEM_REQ` drops immediately. All outputs return to their reset values, `CC`=010, and a later ack is ignored.
